// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues word fetches over req/ack, buffers {pc, word}
// pairs in a small FIFO and hands them to decode; a redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_pc_plus4;
  logic          w_unused_bits;

  // Handshakes: a fetch is outstanding while imem_req=1 and completes in the cycle
  // imem_ack=1 (imem_addr held stable until then); a decode transfer occurs in any
  // cycle with inst_valid=1 and inst_ready=1, except that a redirect cancels it.
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_bits = ^redirect_pc[1:0];
  assign w_pc_plus4    = r_fetch_pc + 32'd4;

  assign inst_valid  = (r_count != '0);
  assign inst        = r_mem_inst[r_rd_ptr];
  assign inst_pc     = r_mem_pc[r_rd_ptr];
  assign imem_req    = (r_state == S_FETCH) || (r_state == S_DROP);
  assign imem_addr   = r_addr;
  assign o_dbg_state = r_state;

  assign w_pop  = inst_valid && inst_ready && !redirect;
  assign w_push = (r_state == S_FETCH) && imem_ack && !redirect;

  assign w_count_after_pop = r_count - {{(CW-1){1'b0}}, w_pop};
  assign w_count_nxt       = w_count_after_pop + {{(CW-1){1'b0}}, w_push};
  // Room for one more word after this edge decides whether the next request may issue.
  assign w_space           = (w_count_nxt < DEPTH_C);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    w_flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redirect_pc;
          w_addr_nxt     = w_redirect_pc;
          w_state_nxt    = S_FETCH;
        end else if (w_count_after_pop < DEPTH_C) begin
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redirect_pc;
          if (imem_ack) begin
            w_addr_nxt = w_redirect_pc;
          end else begin
            // The outstanding request cannot be withdrawn; its response is discarded.
            w_state_nxt = S_DROP;
          end
        end else if (imem_ack) begin
          w_fetch_pc_nxt = w_pc_plus4;
          w_addr_nxt     = w_pc_plus4;
          if (!w_space) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redirect_pc;
          if (imem_ack) begin
            w_addr_nxt  = w_redirect_pc;
            w_state_nxt = S_FETCH;
          end
        end else if (imem_ack) begin
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (w_flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_inst[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a wait-state memory model, a scoreboard of expected
// {pc, inst} pairs popped by an independent monitor, and cycle-exact control checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic [31:0] data_xor;
  int          mem_wait;
  int          wcnt;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_wait wait states with word = addr ^ data_xor.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    wcnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!imem_req) begin
        wcnt     = 0;
        imem_ack = 1'b0;
      end else if (wcnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ data_xor;
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: every accepted head must match the next expected {pc, inst}.
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h inst %h, expected no transfer", inst_pc, inst);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_head", {inst_pc, inst}, sb_exp);
      end
    end
  end

  // driver tasks
  task automatic expect_item(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ data_xor});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic start_phase();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain_and_reset(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b0;
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    redirect   = 1'b0;
    inst_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;
    data_xor    = 32'h0;
    mem_wait    = 0;

    // reset values
    neg();
    neg();
    chk("rst_req",   64'(imem_req),   64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_addr",  64'(imem_addr),  64'h0);
    chk("rst_inst",  64'(inst),       64'h0);
    chk("rst_pc",    64'(inst_pc),    64'h0);
    chk("rst_state", 64'(dbg_state),  64'(ST_IDLE));

    // 1: zero-wait streaming, word = addr, no bubbles
    for (int k = 0; k < 8; k++) expect_item(32'(4 * k));
    start_phase();
    neg();
    chk("p1_idle_req", 64'(imem_req), 64'd0);
    neg();
    chk("p1_req",   64'(imem_req),   64'd1);
    chk("p1_addr0", 64'(imem_addr),  64'h0);
    chk("p1_valid0", 64'(inst_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      neg();
      chk("p1_valid", 64'(inst_valid), 64'd1);
      chk("p1_pc",    64'(inst_pc),    64'(4 * k));
      chk("p1_addr",  64'(imem_addr),  64'(4 * k + 4));
    end
    drain_and_reset("p1", 20);

    // 2: consumer stalled, FIFO fills to 4, then resumes in order
    data_xor = 32'hDEAD_0000;
    mem_wait = 0;
    expect_item(32'h0);
    expect_item(32'h4);
    expect_item(32'h8);
    expect_item(32'hC);
    expect_item(32'h10);
    start_phase();
    repeat (6) neg();
    chk("p2_full_req",   64'(imem_req),   64'd0);
    chk("p2_full_state", 64'(dbg_state),  64'(ST_IDLE));
    chk("p2_full_valid", 64'(inst_valid), 64'd1);
    chk("p2_head",       {inst_pc, inst}, {32'h0, 32'hDEAD_0000});
    neg();
    chk("p2_hold_req", 64'(imem_req), 64'd0);
    cyc();
    inst_ready = 1'b1;
    neg();
    chk("p2_resume_state", 64'(dbg_state), 64'(ST_IDLE));
    neg();
    chk("p2_refetch_req",  64'(imem_req),  64'd1);
    chk("p2_refetch_addr", 64'(imem_addr), 64'h10);
    drain_and_reset("p2", 20);

    // 3: 3 wait states, redirect during the 2nd wait cycle -> DROP
    mem_wait   = 3;
    inst_ready = 1'b0;
    expect_item(32'h100);
    start_phase();
    repeat (6) neg();
    chk("p3_one_valid", 64'(inst_valid), 64'd1);
    chk("p3_one_pc",    64'(inst_pc),    64'h0);
    chk("p3_addr4",     64'(imem_addr),  64'h4);
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    neg();
    cyc();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    neg();
    chk("p3_flush_valid", 64'(inst_valid), 64'd0);
    chk("p3_drop_state",  64'(dbg_state),  64'(ST_DROP));
    chk("p3_drop_req",    64'(imem_req),   64'd1);
    chk("p3_drop_addr",   64'(imem_addr),  64'h4);
    neg();
    chk("p3_hold_addr", 64'(imem_addr), 64'h4);
    neg();
    chk("p3_new_addr",  64'(imem_addr), 64'h100);
    chk("p3_new_state", 64'(dbg_state), 64'(ST_FETCH));
    repeat (3) neg();
    chk("p3_noold_valid", 64'(inst_valid), 64'd0);
    drain_and_reset("p3", 20);

    // 4: redirect coincident with ack, unaligned target
    mem_wait   = 1;
    inst_ready = 1'b1;
    expect_item(32'h0);
    expect_item(32'h200);
    start_phase();
    repeat (4) neg();
    chk("p4_addr4", 64'(imem_addr), 64'h4);
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    neg();
    cyc();
    redirect = 1'b0;
    neg();
    chk("p4_addr",  64'(imem_addr),  64'h200);
    chk("p4_state", 64'(dbg_state),  64'(ST_FETCH));
    chk("p4_valid", 64'(inst_valid), 64'd0);
    drain_and_reset("p4", 20);

    // 5: redirect in IDLE with full FIFO and inst_ready=1
    mem_wait   = 0;
    inst_ready = 1'b0;
    expect_item(32'h300);
    start_phase();
    repeat (6) neg();
    cyc();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    neg();
    chk("p5_full_valid", 64'(inst_valid), 64'd1);
    chk("p5_full_state", 64'(dbg_state),  64'(ST_IDLE));
    cyc();
    redirect = 1'b0;
    neg();
    chk("p5_flush_valid", 64'(inst_valid), 64'd0);
    chk("p5_req",         64'(imem_req),   64'd1);
    chk("p5_addr",        64'(imem_addr),  64'h300);
    drain_and_reset("p5", 20);

    // 6: async reset while in DROP, restart from RESET_PC
    mem_wait   = 3;
    inst_ready = 1'b1;
    start_phase();
    repeat (2) neg();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    cyc();
    redirect = 1'b0;
    neg();
    chk("p6_drop_state", 64'(dbg_state), 64'(ST_DROP));
    #2;
    rst = 1'b0;
    #1;
    chk("p6_rst_req",   64'(imem_req),   64'd0);
    chk("p6_rst_valid", 64'(inst_valid), 64'd0);
    chk("p6_rst_state", 64'(dbg_state),  64'(ST_IDLE));
    chk("p6_rst_addr",  64'(imem_addr),  64'h0);
    expect_item(32'h0);
    start_phase();
    repeat (2) neg();
    chk("p6_restart_req",  64'(imem_req),  64'd1);
    chk("p6_restart_addr", 64'(imem_addr), 64'h0);
    drain_and_reset("p6", 20);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
